// File: rtl/ddr3_port_arbiter.sv
// Shares one MIG app_* port between the capture write path and the USB readback path.
// Combinational strobes with no added latency; writes have priority and bursts are bounded per grant.
module ddr3_port_arbiter #(
  parameter int pADDR_WIDTH      = 30,
  parameter int pDATA_WIDTH      = 64,
  parameter int pMAX_BURST       = 16,
  parameter int pMAX_OUTSTANDING = 32
) (
  input  logic                                  ui_clk,
  input  logic                                  reset,
  input  logic                                  wr_req,
  input  logic [pADDR_WIDTH-1:0]                wr_addr,
  input  logic [pDATA_WIDTH-1:0]                wr_data,
  output logic                                  wr_ack,
  input  logic                                  rd_req,
  input  logic [pADDR_WIDTH-1:0]                rd_addr,
  output logic                                  rd_ack,
  output logic [pDATA_WIDTH-1:0]                rd_data,
  output logic                                  rd_data_valid,
  output logic [pADDR_WIDTH-1:0]                app_addr,
  output logic [2:0]                            app_cmd,
  output logic                                  app_en,
  input  logic                                  app_rdy,
  output logic [pDATA_WIDTH-1:0]                app_wdf_data,
  output logic                                  app_wdf_wren,
  output logic                                  app_wdf_end,
  input  logic                                  app_wdf_rdy,
  input  logic [pDATA_WIDTH-1:0]                app_rd_data,
  input  logic                                  app_rd_data_valid,
  output logic                                  grant_wr,
  output logic                                  grant_rd,
  output logic [$clog2(pMAX_OUTSTANDING):0]     rd_outstanding,
  output logic                                  rd_underflow
);

  localparam int OW = $clog2(pMAX_OUTSTANDING) + 1;
  localparam int BW = (pMAX_BURST > 1) ? $clog2(pMAX_BURST) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_q;
  logic [OW-1:0] out_q;
  logic          uf_q;
  logic          rd_room;
  logic          burst_last;
  logic          accept;

  assign rd_room    = out_q < OW'(pMAX_OUTSTANDING);
  assign burst_last = burst_q == BW'(pMAX_BURST - 1);
  assign accept     = wr_ack | rd_ack;

  always_comb begin
    state_d      = state_q;
    app_cmd      = 3'b000;
    app_addr     = wr_addr;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    wr_ack       = 1'b0;
    rd_ack       = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req)      state_d = WRITE;
        else if (rd_req) state_d = READ;
      end
      WRITE: begin
        app_en       = wr_req & app_wdf_rdy;
        app_wdf_wren = wr_req & app_rdy;
        wr_ack       = wr_req & app_rdy & app_wdf_rdy;
        if (!wr_req)
          state_d = rd_req ? READ : IDLE;
        else if (rd_req && wr_ack && burst_last)
          state_d = READ;
      end
      READ: begin
        app_cmd  = 3'b001;
        app_addr = rd_addr;
        app_en   = rd_req & rd_room;
        rd_ack   = app_en & app_rdy;
        // A pending write reclaims the port when reads are blocked, the burst is spent,
        // or the read grant has not yet made any progress.
        if (!rd_req)
          state_d = wr_req ? WRITE : IDLE;
        else if (wr_req && (!rd_room || (rd_ack && burst_last) ||
                            (burst_q == '0 && !rd_ack)))
          state_d = WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      out_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Saturates so a long single-sided grant yields on the next accept once the other side asks.
      if (state_d != state_q)
        burst_q <= '0;
      else if (accept && !burst_last)
        burst_q <= burst_q + 1'b1;
      case ({rd_ack, app_rd_data_valid})
        2'b10: out_q <= out_q + 1'b1;
        2'b01: begin
          if (out_q == '0) uf_q <= 1'b1;
          else             out_q <= out_q - 1'b1;
        end
        default: out_q <= out_q;
      endcase
    end
  end

  assign app_wdf_end    = app_wdf_wren;
  assign app_wdf_data   = wr_data;
  assign rd_data        = app_rd_data;
  assign rd_data_valid  = app_rd_data_valid;
  assign grant_wr       = state_q == WRITE;
  assign grant_rd       = state_q == READ;
  assign rd_outstanding = out_q;
  assign rd_underflow   = uf_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Bench for ddr3_port_arbiter: vector table, directed corner sequences, and randomized
// traffic compared against a grant-level reference model.
module tb_ddr3_port_arbiter;
  localparam int AW = 30;
  localparam int DW = 64;

  logic          ui_clk = 1'b0;
  logic          reset  = 1'b1;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0, app_rd_data = '0;
  logic          app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0;
  logic          wr_ack, rd_ack, rd_data_valid, app_en, app_wdf_wren, app_wdf_end;
  logic          grant_wr, grant_rd, rd_underflow;
  logic [DW-1:0] rd_data, app_wdf_data;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic [5:0]    rd_outstanding;

  ddr3_port_arbiter dut (
    .ui_clk(ui_clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .grant_wr(grant_wr), .grant_rd(grant_rd),
    .rd_outstanding(rd_outstanding), .rd_underflow(rd_underflow)
  );

  always #5 ui_clk = ~ui_clk;

  // {wr_ack, rd_ack, app_en, app_wdf_wren, app_wdf_end, grant_wr, grant_rd, app_cmd}
  wire [9:0] dut_vec = {wr_ack, rd_ack, app_en, app_wdf_wren, app_wdf_end,
                        grant_wr, grant_rd, app_cmd};

  int n_cmp = 0, n_bad = 0;
  bit chk = 0;
  logic [9:0] c_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: grant 0=none 1=write 2=read, accepts this grant, reads in flight.
  int m_gnt, m_cnt, m_out;
  bit m_uf;

  task automatic model_reset();
    m_gnt = 0; m_cnt = 0; m_out = 0; m_uf = 0;
  endtask

  function automatic logic [9:0] m_vec();
    bit gw, gr, en, we, wa, ra;
    gw = (m_gnt == 1);
    gr = (m_gnt == 2);
    we = gw && wr_req && app_rdy;
    en = gw ? (wr_req && app_wdf_rdy) : (gr && rd_req && m_out < 32);
    wa = we && app_wdf_rdy;
    ra = gr && en && app_rdy;
    return {wa, ra, en, we, we, gw, gr, 2'b00, gr};
  endfunction

  task automatic model_advance();
    logic [9:0] v;
    int nxt;
    bit wa, ra, full;
    v = m_vec(); wa = v[9]; ra = v[8];
    full = (m_out >= 32);
    nxt = m_gnt;
    case (m_gnt)
      0: nxt = wr_req ? 1 : (rd_req ? 2 : 0);
      1: if (!wr_req) nxt = rd_req ? 2 : 0;
         else if (rd_req && wa && m_cnt >= 15) nxt = 2;
      2: if (!rd_req) nxt = wr_req ? 1 : 0;
         else if (wr_req && (full || (ra && m_cnt >= 15) || (m_cnt == 0 && !ra))) nxt = 1;
      default: nxt = 0;
    endcase
    m_cnt = (nxt != m_gnt) ? 0 : m_cnt + int'(wa | ra);
    m_gnt = nxt;
    if (ra && !app_rd_data_valid) m_out++;
    else if (!ra && app_rd_data_valid) begin
      if (m_out == 0) m_uf = 1;
      else m_out--;
    end
  endtask

  // Called at posedge+1 with inputs set; samples mid-cycle, then crosses the next edge.
  task automatic step();
    #3;
    c_vec = dut_vec;
    if (chk) begin
      check("rnd_strobes", c_vec, m_vec());
      check("rnd_outstanding", rd_outstanding, m_out);
      check("rnd_underflow", rd_underflow, m_uf);
      if (m_gnt == 1) check("rnd_wr_addr", app_addr, wr_addr);
      if (m_gnt == 2) check("rnd_rd_addr", app_addr, rd_addr);
      check("rnd_wdata", app_wdf_data, wr_data);
      check("rnd_rdata", {rd_data_valid, rd_data}, {app_rd_data_valid, app_rd_data});
    end
    model_advance();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_req = 0; rd_req = 0; app_rd_data_valid = 0; app_rdy = 1; app_wdf_rdy = 1;
    model_reset();
    @(posedge ui_clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic wr, rd, ardy, wdrdy, rdv;
    logic [9:0] exp;
    int out;
    logic uf;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(logic wr, logic rd, logic ardy, logic wdrdy, logic rdv,
                              logic [9:0] exp, int out, logic uf);
    vec_t t;
    t.wr = wr; t.rd = rd; t.ardy = ardy; t.wdrdy = wdrdy; t.rdv = rdv;
    t.exp = exp; t.out = out; t.uf = uf;
    return t;
  endfunction

  initial begin
    int acks, bad;
    bit exp_w;
    tbl[0]  = mk(0,0,1,1,0, 10'b00_0000_0000, 0, 0);
    tbl[1]  = mk(1,0,1,1,0, 10'b00_0000_0000, 0, 0);  // IDLE cycle, grant next
    tbl[2]  = mk(1,0,1,0,0, 10'b00_0111_0000, 0, 0);  // wdf not ready: wren only
    tbl[3]  = mk(1,0,0,1,0, 10'b00_1001_0000, 0, 0);  // app not ready: en only
    tbl[4]  = mk(1,0,1,1,0, 10'b10_1111_0000, 0, 0);
    tbl[5]  = mk(0,1,1,1,0, 10'b00_0001_0000, 0, 0);  // write drops, read waits
    tbl[6]  = mk(0,1,1,1,0, 10'b01_1000_1001, 0, 0);
    tbl[7]  = mk(0,1,0,1,0, 10'b00_1000_1001, 1, 0);
    tbl[8]  = mk(0,1,1,1,1, 10'b01_1000_1001, 1, 0);  // ack and return together
    tbl[9]  = mk(0,0,1,1,1, 10'b00_0000_1001, 1, 0);
    tbl[10] = mk(0,0,1,1,1, 10'b00_0000_0000, 0, 0);  // return with nothing in flight
    tbl[11] = mk(0,0,1,1,0, 10'b00_0000_0000, 0, 1);

    #3;
    check("reset_strobes", dut_vec, 10'd0);
    check("reset_counters", {rd_outstanding, rd_underflow}, 7'd0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      wr_req = tbl[i].wr; rd_req = tbl[i].rd; app_rdy = tbl[i].ardy;
      app_wdf_rdy = tbl[i].wdrdy; app_rd_data_valid = tbl[i].rdv;
      #3;
      check($sformatf("tbl%0d_strobes", i), dut_vec, tbl[i].exp);
      check($sformatf("tbl%0d_count", i), {rd_outstanding, rd_underflow}, {6'(tbl[i].out), tbl[i].uf});
      #2;
      @(posedge ui_clk);
      #1;
    end

    // Write-only stream keeps the grant and acks every cycle.
    do_reset();
    wr_req = 1;
    step();
    bad = 0;
    repeat (120) begin
      step();
      if (!(c_vec[9] && c_vec[4])) bad++;
    end
    check("wr_stream_bad_cycles", bad, 0);

    // Both sides held: 16 writes then 16 reads, alternating.
    do_reset();
    wr_req = 1; rd_req = 1;
    step();
    bad = 0;
    for (int i = 0; i < 96; i++) begin
      step();
      app_rd_data_valid = c_vec[8];
      exp_w = ((i / 16) % 2) == 0;
      if (c_vec[9] != exp_w || c_vec[8] != !exp_w) bad++;
    end
    check("alternate_bad_cycles", bad, 0);
    app_rd_data_valid = 0;

    // Outstanding cap.
    do_reset();
    rd_req = 1;
    step();
    acks = 0;
    repeat (40) begin step(); acks += int'(c_vec[8]); end
    check("cap_acks", acks, 32);
    check("cap_app_en", c_vec[7], 1'b0);
    check("cap_count", rd_outstanding, 32);
    app_rd_data_valid = 1;
    step();
    app_rd_data_valid = 0;
    check("cap_en_while_full", c_vec[7], 1'b0);
    acks = 0;
    repeat (5) begin step(); acks += int'(c_vec[8]); end
    check("cap_one_more_ack", acks, 1);

    // Simultaneous ack/return, then underflow stickiness.
    do_reset();
    rd_req = 1;
    step();
    repeat (5) step();
    check("count_five", rd_outstanding, 5);
    app_rd_data_valid = 1;
    step();
    check("same_cycle_ack", c_vec[8], 1'b1);
    check("same_cycle_count", rd_outstanding, 5);
    rd_req = 0;
    repeat (5) step();
    check("drained_count", {rd_outstanding, rd_underflow}, 7'd0);
    step();
    app_rd_data_valid = 0;
    repeat (3) step();
    check("underflow_sticky", rd_underflow, 1'b1);

    // Reset in the middle of a read grant.
    do_reset();
    rd_req = 1;
    step();
    repeat (10) step();
    check("pre_reset_count", rd_outstanding, 10);
    reset = 1;
    #2;
    check("mid_reset_strobes", dut_vec, 10'd0);
    check("mid_reset_counters", {rd_outstanding, rd_underflow}, 7'd0);
    model_reset();
    @(posedge ui_clk);
    #1;
    reset = 0;
    step();
    check("post_reset_idle", c_vec, 10'd0);

    // Randomized traffic against the model.
    do_reset();
    chk = 1;
    repeat (3000) begin
      wr_req      = ($urandom_range(0, 3) != 0);
      rd_req      = ($urandom_range(0, 2) != 0);
      app_rdy     = ($urandom_range(0, 4) != 0);
      app_wdf_rdy = ($urandom_range(0, 4) != 0);
      app_rd_data_valid = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      wr_addr     = AW'($urandom);
      rd_addr     = AW'($urandom);
      wr_data     = {$urandom, $urandom};
      app_rd_data = {$urandom, $urandom};
      step();
    end
    chk = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
